// File: rtl/seq_fsm_pkg.sv
// Shared definitions for the serial-pattern FSM blocks: state encodings,
// the default pattern and the repetition-count helper.
package seq_fsm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    localparam logic [3:0] PATTERN_DEFAULT = 4'b1100;

    // A requested count of zero still sends the word once.
    function automatic logic [3:0] eff_count(input logic [3:0] count);
        return (count == 4'd0) ? 4'd1 : count;
    endfunction

endpackage

// File: rtl/seq_window_cmp.sv
// Sliding-window comparator: keeps the previous WIDTH-1 stream bits and flags,
// one register stage later, when they plus the incoming bit equal PATTERN.
module seq_window_cmp
    import seq_fsm_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] PATTERN = WIDTH'(PATTERN_DEFAULT)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic bit_valid,
    input  logic bit_in,
    input  logic fill_ok,
    output logic match
);

    logic [WIDTH-2:0] hist_q, hist_d, hist_src;
    logic [WIDTH-1:0] win;
    logic             match_q, match_d;

    // clr discards old history but still keeps the bit arriving alongside it.
    always_comb begin
        hist_src = clr ? '0 : hist_q;
        win      = {hist_src, bit_in};
        match_d  = bit_valid && fill_ok && (win == PATTERN);
        hist_d   = bit_valid ? win[WIDTH-2:0] : hist_src;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q  <= '0;
            match_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            match_q <= match_d;
        end
    end

    assign match = match_q;

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: accepts a word over valid/ready, shifts it out
// MSB-first a programmable number of times, and flags PATTERN completions.
module seq_pattern_tx
    import seq_fsm_pkg::*;
#(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] PATTERN  = WIDTH'(PATTERN_DEFAULT),
    parameter logic             IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [3:0]       load_count,
    output logic             tx_bit,
    output logic             tx_valid,
    output logic             busy,
    output logic             done,
    output logic             match,
    output logic [1:0]       state
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] held_q, held_d;
    logic [3:0]       reps_q, reps_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fill_q, fill_d;
    logic             tx_bit_q, tx_bit_d;
    logic             tx_valid_q, tx_valid_d;
    logic             done_q, done_d;
    logic             accept;
    logic             fill_ok;

    assign load_ready = (state_q == ST_IDLE);
    assign busy       = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign accept     = load_valid && load_ready;

    // Outputs are registered, so the _d terms describe the bit on the wire
    // in the cycle after this edge; cnt_q indexes the bit currently driven.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        held_d     = held_q;
        reps_d     = reps_q;
        cnt_d      = cnt_q;
        fill_d     = fill_q;
        tx_bit_d   = IDLE_BIT;
        tx_valid_d = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_SHIFT;
                    held_d     = load_data;
                    shift_d    = load_data << 1;
                    reps_d     = eff_count(load_count);
                    cnt_d      = '0;
                    fill_d     = 1'b0;
                    tx_bit_d   = load_data[WIDTH-1];
                    tx_valid_d = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == LAST) begin
                    fill_d = 1'b1;
                    if (reps_q > 4'd1) begin
                        reps_d     = reps_q - 4'd1;
                        cnt_d      = '0;
                        shift_d    = held_q << 1;
                        tx_bit_d   = held_q[WIDTH-1];
                        tx_valid_d = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d      = cnt_q + 1'b1;
                    shift_d    = shift_q << 1;
                    tx_bit_d   = shift_q[WIDTH-1];
                    tx_valid_d = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The next bit closes a full window once a whole word has gone out.
    assign fill_ok = fill_d || (cnt_d == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            held_q     <= '0;
            reps_q     <= '0;
            cnt_q      <= '0;
            fill_q     <= 1'b0;
            tx_bit_q   <= IDLE_BIT;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            held_q     <= held_d;
            reps_q     <= reps_d;
            cnt_q      <= cnt_d;
            fill_q     <= fill_d;
            tx_bit_q   <= tx_bit_d;
            tx_valid_q <= tx_valid_d;
            done_q     <= done_d;
        end
    end

    seq_window_cmp #(
        .WIDTH   (WIDTH),
        .PATTERN (PATTERN)
    ) u_win (
        .clk       (clk),
        .reset     (reset),
        .clr       (accept),
        .bit_valid (tx_valid_d),
        .bit_in    (tx_bit_d),
        .fill_ok   (fill_ok),
        .match     (match)
    );

    assign tx_bit   = tx_bit_q;
    assign tx_valid = tx_valid_q;
    assign done     = done_q;
    assign state    = state_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: per-cycle expected streams, match flags
// and handshake timing, computed by hand for WIDTH=4, PATTERN=1100.
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid;
    logic       load_ready;
    logic [3:0] load_data;
    logic [3:0] load_count;
    logic       tx_bit;
    logic       tx_valid;
    logic       busy;
    logic       done;
    logic       match;
    logic [1:0] state;

    int n_pass = 0;
    int n_total = 0;

    seq_pattern_tx #(
        .WIDTH    (4),
        .PATTERN  (4'b1100),
        .IDLE_BIT (1'b0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_count (load_count),
        .tx_bit     (tx_bit),
        .tx_valid   (tx_valid),
        .busy       (busy),
        .done       (done),
        .match      (match),
        .state      (state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Offer word d at the current negedge; check every cycle through DONE and
    // the return to IDLE. bits/mt list the stream first-bit-first in [n-1:0].
    // With hold set, load_valid stays high carrying hd/hc during the transfer.
    task automatic send(input string nm, input logic [3:0] d, input logic [3:0] c,
                        input int n, input logic [15:0] bits, input logic [15:0] mt,
                        input logic hold, input logic [3:0] hd, input logic [3:0] hc);
        load_valid = 1'b1;
        load_data  = d;
        load_count = c;
        chk($sformatf("%s:rdy_idle", nm), load_ready, 1);
        @(negedge clk);
        if (hold) begin
            load_data  = hd;
            load_count = hc;
        end else begin
            load_valid = 1'b0;
        end
        for (int k = 1; k <= n; k++) begin
            chk($sformatf("%s:bit%0d", nm, k), tx_bit, bits[n-k]);
            chk($sformatf("%s:vld%0d", nm, k), tx_valid, 1);
            chk($sformatf("%s:match%0d", nm, k), match, mt[n-k]);
            chk($sformatf("%s:rdy%0d", nm, k), load_ready, 0);
            chk($sformatf("%s:done%0d", nm, k), done, 0);
            chk($sformatf("%s:state%0d", nm, k), state, 1);
            @(negedge clk);
        end
        chk($sformatf("%s:done_pulse", nm), done, 1);
        chk($sformatf("%s:done_vld", nm), tx_valid, 0);
        chk($sformatf("%s:done_bit", nm), tx_bit, 0);
        chk($sformatf("%s:done_busy", nm), busy, 1);
        chk($sformatf("%s:done_rdy", nm), load_ready, 0);
        chk($sformatf("%s:done_match", nm), match, 0);
        chk($sformatf("%s:done_state", nm), state, 2);
        @(negedge clk);
        chk($sformatf("%s:idle_rdy", nm), load_ready, 1);
        chk($sformatf("%s:idle_done", nm), done, 0);
        chk($sformatf("%s:idle_busy", nm), busy, 0);
        chk($sformatf("%s:idle_state", nm), state, 0);
    endtask

    initial begin
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = 4'h0;
        load_count = 4'h0;
        repeat (2) @(negedge clk);
        chk("rst:state", state, 0);
        chk("rst:rdy", load_ready, 1);
        chk("rst:bit", tx_bit, 0);
        chk("rst:vld", tx_valid, 0);
        chk("rst:busy", busy, 0);
        chk("rst:done", done, 0);
        chk("rst:match", match, 0);
        reset = 1'b0;
        @(negedge clk);

        send("t1100", 4'b1100, 4'd1, 4, 16'b1100, 16'b0001, 1'b0, 4'h0, 4'h0);
        send("t0110x2", 4'b0110, 4'd2, 8, 16'b0110_0110, 16'b0000_1000, 1'b0, 4'h0, 4'h0);
        send("t1010c0", 4'b1010, 4'd0, 4, 16'b1010, 16'b0000, 1'b0, 4'h0, 4'h0);

        // Busy-time offers must not disturb the stream; held word goes next.
        send("hold", 4'b0011, 4'd1, 4, 16'b0011, 16'b0000, 1'b1, 4'b1100, 4'd1);
        send("held", 4'b1100, 4'd1, 4, 16'b1100, 16'b0001, 1'b0, 4'h0, 4'h0);

        // 0001 followed by 1000 contains 1100 only if history leaks across.
        send("b2b_a", 4'b0001, 4'd1, 4, 16'b0001, 16'b0000, 1'b0, 4'h0, 4'h0);
        send("b2b_b", 4'b1000, 4'd1, 4, 16'b1000, 16'b0000, 1'b0, 4'h0, 4'h0);

        // Reset during bit 3 of a 3-repetition transfer.
        load_valid = 1'b1;
        load_data  = 4'b1100;
        load_count = 4'd3;
        @(negedge clk);
        load_valid = 1'b0;
        chk("mrst:bit1", tx_bit, 1);
        @(negedge clk);
        chk("mrst:bit2", tx_bit, 1);
        @(negedge clk);
        chk("mrst:bit3", tx_bit, 0);
        chk("mrst:vld3", tx_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst:vld", tx_valid, 0);
        chk("mrst:bit", tx_bit, 0);
        chk("mrst:busy", busy, 0);
        chk("mrst:done", done, 0);
        chk("mrst:match", match, 0);
        chk("mrst:state", state, 0);
        chk("mrst:rdy", load_ready, 1);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("mrst:quiet_done%0d", k), done, 0);
            chk($sformatf("mrst:quiet_vld%0d", k), tx_valid, 0);
        end
        send("recover", 4'b1100, 4'd1, 4, 16'b1100, 16'b0001, 1'b0, 4'h0, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
